// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps one request in flight to instruction
// memory and hands each returned word with its PC to decode over valid/ready.
module fetch_unit #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_ren,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_imem_valid,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    output logic        o_fetch_fault
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SQUASH = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic        handshake;
    logic        aligned;

    assign handshake   = o_inst_valid & i_inst_ready;
    assign aligned     = (pc[1:0] == 2'b00);
    assign o_imem_addr = pc;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (o_imem_ren) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A redirect turns the outstanding read into one to discard,
                // unless its response is already arriving this cycle.
                if (i_redirect) begin
                    state_nxt = i_imem_valid ? ST_IDLE : ST_SQUASH;
                end else if (i_imem_valid) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SQUASH: begin
                if (i_imem_valid) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_imem_ren    = i_rst_n & (state == ST_IDLE) & ~i_redirect & aligned
                        & (~o_inst_valid | i_inst_ready);
        o_fetch_fault = i_rst_n & (state == ST_IDLE) & ~aligned;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pc           <= RESET_ADDR;
            o_inst_valid <= 1'b0;
            o_inst       <= NOP_INST;
            o_inst_pc    <= RESET_ADDR;
        end else if (i_redirect) begin
            pc           <= i_redirect_pc;
            o_inst_valid <= 1'b0;
            o_inst       <= NOP_INST;
        end else if (state == ST_WAIT && i_imem_valid) begin
            // A response landing with a handshake simply overwrites the slot.
            o_inst       <= i_imem_rdata;
            o_inst_pc    <= pc;
            o_inst_valid <= 1'b1;
            pc           <= pc + 32'd4;
        end else if (handshake) begin
            o_inst_valid <= 1'b0;
            o_inst       <= NOP_INST;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: latency-programmable memory responder, a queue of expected
// {pc, inst} pairs filled at request time, cycle vectors for the directed sequences.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        o_imem_ren;
    logic [31:0] o_imem_addr;
    logic [31:0] i_imem_rdata = '0;
    logic        i_imem_valid = 1'b0;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = '0;
    logic [31:0] o_inst;
    logic [31:0] o_inst_pc;
    logic        o_inst_valid;
    logic        i_inst_ready = 1'b0;
    logic        o_fetch_fault;

    fetch_unit #(.RESET_ADDR(32'h0000_0000), .NOP_INST(NOP)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n),
        .o_imem_ren(o_imem_ren), .o_imem_addr(o_imem_addr),
        .i_imem_rdata(i_imem_rdata), .i_imem_valid(i_imem_valid),
        .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
        .o_inst(o_inst), .o_inst_pc(o_inst_pc), .o_inst_valid(o_inst_valid),
        .i_inst_ready(i_inst_ready), .o_fetch_fault(o_fetch_fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    typedef struct {
        logic        redir;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_ren;
        logic [31:0] e_addr;
        logic        e_valid;
        logic        e_fault;
    } vec_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          lat = 1;
    logic        rst_val = 1'b0;
    logic        mem_busy = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;
    logic        s_ren, s_valid, s_fault;
    logic [31:0] s_addr;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, exp);
        end
    endtask

    // One clock cycle: drive inputs at negedge, sample combinational outputs 1ns later.
    task automatic cyc(input logic redir, input logic [31:0] rpc, input logic rdy);
        @(negedge clk);
        i_rst_n       = rst_val;
        i_redirect    = redir;
        i_redirect_pc = rpc;
        i_inst_ready  = rdy;
        i_imem_valid  = 1'b0;
        if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                i_imem_valid = 1'b1;
                i_imem_rdata = memf(mem_addr);
                mem_busy     = 1'b0;
            end
        end
        #1;
        s_ren = o_imem_ren; s_addr = o_imem_addr; s_valid = o_inst_valid; s_fault = o_fetch_fault;
        if (!rst_val) begin
            chk("ren_in_reset", {31'd0, s_ren}, 32'd0);
            chk("fault_in_reset", {31'd0, s_fault}, 32'd0);
            sb.delete();
        end else begin
            if (s_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", {31'd0, s_valid}, 32'd0);
                end else begin
                    chk("inst_pc", o_inst_pc, sb[0].pc);
                    chk("inst", o_inst, sb[0].inst);
                    if (rdy) void'(sb.pop_front());
                end
            end else begin
                chk("nop_when_empty", o_inst, NOP);
            end
            if (redir) sb.delete();
            if (s_ren) begin
                chk("one_outstanding", {31'd0, mem_busy}, 32'd0);
                sb.push_back('{pc: s_addr, inst: memf(s_addr)});
                mem_busy = 1'b1;
                mem_cnt  = lat;
                mem_addr = s_addr;
            end
        end
    endtask

    task automatic apply(input vec_t v);
        cyc(v.redir, v.rpc, v.rdy);
        chk("vec_ren", {31'd0, s_ren}, {31'd0, v.e_ren});
        chk("vec_addr", s_addr, v.e_addr);
        chk("vec_valid", {31'd0, s_valid}, {31'd0, v.e_valid});
        chk("vec_fault", {31'd0, s_fault}, {31'd0, v.e_fault});
    endtask

    task automatic do_reset(input int n);
        rst_val = 1'b0;
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0);
        rst_val = 1'b1;
    endtask

    task automatic run_until_valid(input logic rdy);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, '0, rdy);
            if (s_valid) return;
        end
        chk("valid_timeout", 32'd0, 32'd1);
    endtask

    vec_t seq_v[7];
    vec_t flt_v[6];

    initial begin
        seq_v[0] = '{1'b0, '0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0};
        seq_v[1] = '{1'b0, '0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0};
        seq_v[2] = '{1'b0, '0, 1'b1, 1'b1, 32'h4, 1'b1, 1'b0};
        seq_v[3] = '{1'b0, '0, 1'b1, 1'b0, 32'h4, 1'b0, 1'b0};
        seq_v[4] = '{1'b0, '0, 1'b1, 1'b1, 32'h8, 1'b1, 1'b0};
        seq_v[5] = '{1'b0, '0, 1'b1, 1'b0, 32'h8, 1'b0, 1'b0};
        seq_v[6] = '{1'b0, '0, 1'b1, 1'b1, 32'hC, 1'b1, 1'b0};

        flt_v[0] = '{1'b1, 32'h102, 1'b1, 1'b0, 32'h404, 1'b1, 1'b0};
        flt_v[1] = '{1'b0, '0,      1'b1, 1'b0, 32'h102, 1'b0, 1'b1};
        flt_v[2] = '{1'b0, '0,      1'b1, 1'b0, 32'h102, 1'b0, 1'b1};
        flt_v[3] = '{1'b0, '0,      1'b1, 1'b0, 32'h102, 1'b0, 1'b1};
        flt_v[4] = '{1'b1, 32'h200, 1'b1, 1'b0, 32'h102, 1'b0, 1'b1};
        flt_v[5] = '{1'b0, '0,      1'b1, 1'b1, 32'h200, 1'b0, 1'b0};

        // Reset, then sequential fetch with L=1.
        do_reset(2);
        chk("reset_inst_pc", o_inst_pc, 32'h0);
        foreach (seq_v[i]) apply(seq_v[i]);

        // Backpressure: held word stays put, no request until ready.
        cyc(1'b0, '0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, '0, 1'b0);
            chk("bp_no_ren", {31'd0, s_ren}, 32'd0);
            chk("bp_valid", {31'd0, s_valid}, 32'd1);
        end
        lat = 3;
        cyc(1'b0, '0, 1'b1);
        chk("bp_release_ren", {31'd0, s_ren}, 32'd1);
        chk("bp_release_addr", s_addr, 32'h10);

        // Redirect while WAIT: squashed response must not surface.
        cyc(1'b1, 32'h100, 1'b1);
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, '0, 1'b1);
            chk("squash_no_ren", {31'd0, s_ren}, 32'd0);
            chk("squash_no_valid", {31'd0, s_valid}, 32'd0);
        end
        cyc(1'b0, '0, 1'b1);
        chk("redir_ren", {31'd0, s_ren}, 32'd1);
        chk("redir_addr", s_addr, 32'h100);
        lat = 2;
        run_until_valid(1'b1);
        chk("redir_pc", o_inst_pc, 32'h100);

        // Redirect coinciding with the response (L=2, request just issued).
        cyc(1'b0, '0, 1'b1);
        cyc(1'b1, 32'h300, 1'b1);
        cyc(1'b0, '0, 1'b1);
        chk("same_cycle_ren", {31'd0, s_ren}, 32'd1);
        chk("same_cycle_addr", s_addr, 32'h300);
        run_until_valid(1'b0);
        chk("same_cycle_pc", o_inst_pc, 32'h300);

        // Redirect together with a completing handshake.
        cyc(1'b1, 32'h400, 1'b1);
        chk("hs_redir_no_ren", {31'd0, s_ren}, 32'd0);
        cyc(1'b0, '0, 1'b1);
        chk("hs_redir_ren", {31'd0, s_ren}, 32'd1);
        chk("hs_redir_addr", s_addr, 32'h400);
        chk("hs_redir_cleared", {31'd0, s_valid}, 32'd0);
        run_until_valid(1'b0);

        // Misaligned redirect halts fetch until an aligned redirect.
        foreach (flt_v[i]) apply(flt_v[i]);
        run_until_valid(1'b0);

        // PC wrap at the top of the address space.
        cyc(1'b1, 32'hFFFF_FFFC, 1'b1);
        cyc(1'b0, '0, 1'b1);
        chk("wrap_ren", {31'd0, s_ren}, 32'd1);
        chk("wrap_addr", s_addr, 32'hFFFF_FFFC);
        run_until_valid(1'b1);
        chk("wrap_next_ren", {31'd0, s_ren}, 32'd1);
        chk("wrap_next_addr", s_addr, 32'h0);

        // Reset while WAIT; the late response arrives during reset and is ignored.
        run_until_valid(1'b0);
        lat = 3;
        cyc(1'b0, '0, 1'b1);
        chk("pre_reset_addr", s_addr, 32'h4);
        do_reset(3);
        cyc(1'b0, '0, 1'b1);
        chk("restart_ren", {31'd0, s_ren}, 32'd1);
        chk("restart_addr", s_addr, 32'h0);
        chk("restart_valid", {31'd0, s_valid}, 32'd0);
        chk("restart_inst_pc", o_inst_pc, 32'h0);
        run_until_valid(1'b1);
        chk("restart_pc", o_inst_pc, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
